turn_signal_controller: RTL

//  Mode controller and sequencer for a tail-light cluster: 3 lamps left, 3 lamps right.
//  - Arbitrates the driver requests: left, right, hazard and brake.
//  - Owns the blink timebase and advances the sweep pattern on each tick.
//  - Drives both lamp groups from registered outputs.
//  - Sits between the debounced switch inputs and the board LED pins.

---
 rtl/turn_signal_pkg.sv | 33 +++
 rtl/turn_signal_controller_if.sv | 37 +++
 rtl/tick_prescaler.sv | 29 ++
 rtl/turn_signal_controller.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/turn_signal_pkg.sv
// Shared encodings for the tail-light turn-signal controller.
// Holds the mode encodings, the lamp patterns and the sweep lookup.
package turn_signal_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_e;

  localparam logic [2:0] PAT_0     = 3'b000;
  localparam logic [2:0] PAT_1     = 3'b001;
  localparam logic [2:0] PAT_2     = 3'b011;
  localparam logic [2:0] PAT_3     = 3'b111;
  localparam logic [2:0] LAMPS_OFF = 3'b000;
  localparam logic [2:0] LAMPS_ON  = 3'b111;

  // Lamps fill outward from the innermost bit.
  function automatic logic [2:0] sweep(
    input logic [1:0] ph
  );
    logic [2:0] p;
    unique case (ph)
      2'd0:    p = PAT_0;
      2'd1:    p = PAT_1;
      2'd2:    p = PAT_2;
      default: p = PAT_3;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/turn_signal_controller_if.sv
// Request/lamp bundle between the switches and the lamp controller.
// slave: controller side (requests in, lamps/mode/tick out); master: driver side.
interface turn_signal_controller_if;
  import turn_signal_pkg::*;

  logic       left_req;
  logic       right_req;
  logic       hazard_req;
  logic       brake;
  logic [2:0] lights_left;
  logic [2:0] lights_right;
  mode_e      mode;
  logic       tick;

  modport master (
    output left_req,
    output right_req,
    output hazard_req,
    output brake,
    input  lights_left,
    input  lights_right,
    input  mode,
    input  tick
  );

  modport slave (
    input  left_req,
    input  right_req,
    input  hazard_req,
    input  brake,
    output lights_left,
    output lights_right,
    output mode,
    output tick
  );

endinterface

// File: rtl/tick_prescaler.sv
// Sweep timebase: counts 0..TICK_DIV-1, tick high on the last count.
// Ports: clock, reset_n (async low), clear (restart at 0), tick (strobe).
module tick_prescaler #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear || r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/turn_signal_controller.sv
// Tail-light mode arbiter and sweep sequencer, 3 lamps per side.
// Ports: clock, reset_n (async low), bus (turn_signal_controller_if.slave).
module turn_signal_controller
  import turn_signal_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter bit SYNC_EN  = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  turn_signal_controller_if.slave   bus
);

  // {brake, hazard, right, left}
  logic [3:0] w_req;
  logic [3:0] w_req_s;

  assign w_req = {bus.brake, bus.hazard_req,
                  bus.right_req, bus.left_req};

  generate
    if (SYNC_EN) begin : g_sync
      logic [3:0] r_meta;
      logic [3:0] r_sync;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_meta <= '0;
          r_sync <= '0;
        end else begin
          r_meta <= w_req;
          r_sync <= r_meta;
        end
      end

      assign w_req_s = r_sync;
    end else begin : g_nosync
      assign w_req_s = w_req;
    end
  endgenerate

  logic w_left_s;
  logic w_right_s;
  logic w_haz_s;
  logic w_brake_s;

  assign w_left_s  = w_req_s[0];
  assign w_right_s = w_req_s[1];
  assign w_haz_s   = w_req_s[2];
  assign w_brake_s = w_req_s[3];

  mode_e      r_state;
  mode_e      w_next;
  logic       w_mode_chg;
  logic       w_tick;
  logic [1:0] r_phase;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= MODE_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Conditions are made mutually exclusive so hazard wins.
  always_comb begin
    w_next = MODE_IDLE;
    unique case (1'b1)
      (w_haz_s | (w_left_s & w_right_s)):
        w_next = MODE_HAZARD;
      (!w_haz_s & w_left_s & !w_right_s):
        w_next = MODE_LEFT;
      (!w_haz_s & !w_left_s & w_right_s):
        w_next = MODE_RIGHT;
      default:
        w_next = MODE_IDLE;
    endcase
  end

  // A mode change restarts both the timebase and the pattern.
  assign w_mode_chg = (w_next != r_state);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_mode_chg),
    .tick    (w_tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= 2'd0;
    end else if (w_mode_chg || r_state == MODE_IDLE) begin
      r_phase <= 2'd0;
    end else if (w_tick) begin
      r_phase <= r_phase + 2'd1;
    end
  end

  logic [2:0] w_brk;
  logic [2:0] w_ll_d;
  logic [2:0] w_lr_d;

  assign w_brk = w_brake_s ? LAMPS_ON : LAMPS_OFF;

  always_comb begin
    w_ll_d = LAMPS_OFF;
    w_lr_d = LAMPS_OFF;
    unique case (r_state)
      MODE_LEFT: begin
        w_ll_d = sweep(r_phase);
        w_lr_d = w_brk;
      end
      MODE_RIGHT: begin
        w_ll_d = w_brk;
        w_lr_d = sweep(r_phase);
      end
      MODE_HAZARD: begin
        w_ll_d = r_phase[0] ? LAMPS_ON : LAMPS_OFF;
        w_lr_d = r_phase[0] ? LAMPS_ON : LAMPS_OFF;
      end
      default: begin
        w_ll_d = w_brk;
        w_lr_d = w_brk;
      end
    endcase
  end

  logic [2:0] r_lights_left;
  logic [2:0] r_lights_right;
  mode_e      r_mode;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lights_left  <= LAMPS_OFF;
      r_lights_right <= LAMPS_OFF;
      r_mode         <= MODE_IDLE;
    end else begin
      r_lights_left  <= w_ll_d;
      r_lights_right <= w_lr_d;
      r_mode         <= r_state;
    end
  end

  assign bus.lights_left  = r_lights_left;
  assign bus.lights_right = r_lights_right;
  assign bus.mode         = r_mode;
  assign bus.tick         = w_tick;

endmodule
